// File: rtl/regfile_op_sequencer.sv
// Register-file ALU sequencer: accept -> read -> exec -> write -> done; writeback 3 edges after accept, 5-cycle issue rate.
// One instruction in flight; instr_ready only in IDLE, result held in DONE until done_ready.
module regfile_op_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [2:0]            instr_op,
   input  logic [ADDR_WIDTH-1:0] instr_rs1,
   input  logic [ADDR_WIDTH-1:0] instr_rs2,
   input  logic [ADDR_WIDTH-1:0] instr_rd,
   output logic [ADDR_WIDTH-1:0] read_register1,
   output logic [ADDR_WIDTH-1:0] read_register2,
   input  logic [DATA_WIDTH-1:0] read_data1,
   input  logic [DATA_WIDTH-1:0] read_data2,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] write_register,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  done_valid,
   input  logic                  done_ready,
   output logic [DATA_WIDTH-1:0] done_result,
   output logic                  done_zero,
   output logic                  done_carry,
   output logic                  busy
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] READ  = 3'd1;
   localparam logic [2:0] EXEC  = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_MOV = 3'd6;
   localparam logic [2:0] OP_CMP = 3'd7;

   typedef struct packed {
      logic [2:0]            op;
      logic [ADDR_WIDTH-1:0] rs1;
      logic [ADDR_WIDTH-1:0] rs2;
      logic [ADDR_WIDTH-1:0] rd;
   } instr_t;

   logic [2:0]            state_q;
   instr_t                instr_q;
   logic [DATA_WIDTH-1:0] opa_q;
   logic [DATA_WIDTH-1:0] opb_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  zero_q;
   logic                  carry_q;

   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_carry;

   // Carry out of ADD and borrow out of SUB/CMP both land in the extra top bit.
   always_comb begin
      alu_result = '0;
      alu_carry  = 1'b0;
      case (instr_q.op)
         OP_ADD:         {alu_carry, alu_result} = {1'b0, opa_q} + {1'b0, opb_q};
         OP_SUB, OP_CMP: {alu_carry, alu_result} = {1'b0, opa_q} - {1'b0, opb_q};
         OP_AND:         alu_result = opa_q & opb_q;
         OP_OR:          alu_result = opa_q | opb_q;
         OP_XOR:         alu_result = opa_q ^ opb_q;
         OP_SHL: begin
            alu_result = {opa_q[DATA_WIDTH-2:0], 1'b0};
            alu_carry  = opa_q[DATA_WIDTH-1];
         end
         OP_MOV:         alu_result = opa_q;
         default:        alu_result = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         instr_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (instr_valid) begin
                  instr_q.op  <= instr_op;
                  instr_q.rs1 <= instr_rs1;
                  instr_q.rs2 <= instr_rs2;
                  instr_q.rd  <= instr_rd;
                  state_q     <= READ;
               end
            end
            READ: begin
               opa_q   <= read_data1;
               opb_q   <= read_data2;
               state_q <= EXEC;
            end
            EXEC: begin
               result_q <= alu_result;
               zero_q   <= (alu_result == '0);
               carry_q  <= alu_carry;
               state_q  <= WRITE;
            end
            WRITE: state_q <= DONE;
            DONE: begin
               if (done_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The register file lets a write beat its own reset, so the strobe must die with reset.
   assign write_enable   = (state_q == WRITE) && (instr_q.op != OP_CMP) && !reset;
   assign instr_ready    = (state_q == IDLE) && !reset;
   assign done_valid     = (state_q == DONE) && !reset;
   assign busy           = (state_q != IDLE) && !reset;

   assign read_register1 = instr_q.rs1;
   assign read_register2 = instr_q.rs2;
   assign write_register = instr_q.rd;
   assign write_data     = result_q;
   assign done_result    = result_q;
   assign done_zero      = zero_q;
   assign done_carry     = carry_q;

endmodule
